// File: rtl/hmac_pkg.sv
// hmac_pkg: shared SHA-2 message types and the byte-strobe decoder.
package hmac_pkg;

    typedef logic [31:0] sha_word_t;

    typedef struct packed {
        sha_word_t  data;
        logic [3:0] mask;
    } sha_fifo_t;

    // Returns {legal, nbytes}; only contiguous strobes from lane 0 are legal.
    function automatic logic [3:0] strb_nbytes(logic [3:0] s);
        return s == 4'b0001 ? 4'b1001 :
               s == 4'b0011 ? 4'b1010 :
               s == 4'b0111 ? 4'b1011 :
               s == 4'b1111 ? 4'b1100 : 4'b0000;
    endfunction

endpackage

// File: rtl/sha2_msg_pack.sv
// sha2_msg_pack: repacks little-endian bus writes into big-endian masked FIFO words,
// counts message bits and flushes the 1-3 byte residue on hash_process.
module sha2_msg_pack
    import hmac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        sha_en,
    input  logic        hash_start,
    input  logic        hash_process,
    input  logic        wipe_secret,
    input  sha_word_t   wipe_v,
    input  logic        msg_wvalid,
    input  logic [31:0] msg_wdata,
    input  logic [3:0]  msg_wstrb,
    output logic        msg_wready,
    output logic        fifo_wvalid,
    output sha_fifo_t   fifo_wdata,
    input  logic        fifo_wready,
    output logic [63:0] message_length,
    output logic        err_strb,
    output logic        err_drop
);

    typedef enum logic [1:0] {StIdle, StActive, StFlush, StDone} pack_st_e;

    pack_st_e    st_q, st_d;
    logic [1:0]  cnt_q;
    logic [23:0] acc_q;
    logic [3:0]  sn;
    logic [2:0]  n, total;
    logic        legal, accept, take, out_free, flush_load;
    logic [23:0] acc_m;
    logic [31:0] din;
    logic [55:0] merged;
    logic [3:0]  fmask;

    assign sn         = strb_nbytes(msg_wstrb);
    assign n          = sn[2:0];
    assign legal      = sn[3];
    assign out_free   = !fifo_wvalid || fifo_wready;
    assign msg_wready = st_q == StActive ? out_free : st_q != StFlush;
    assign accept     = msg_wvalid && msg_wready;
    assign take       = accept && st_q == StActive && legal;
    // Residual bytes are left-aligned in acc_q; bytes beyond cnt may hold wipe data.
    assign acc_m      = acc_q & ~(24'hffffff >> {cnt_q, 3'b000});
    assign din        = {msg_wdata[7:0], msg_wdata[15:8], msg_wdata[23:16], msg_wdata[31:24]}
                        & ~(32'hffffffff >> {n, 3'b000});
    assign merged     = {acc_m, 32'h0} | ({din, 24'h0} >> {cnt_q, 3'b000});
    assign total      = {1'b0, cnt_q} + n;
    assign flush_load = st_q == StFlush && cnt_q != 2'd0 && out_free;
    assign fmask      = 4'(4'b1110 << (2'd3 - cnt_q));

    always_comb begin
        st_d = st_q;
        if (st_q == StActive && hash_process) st_d = StFlush;
        if (st_q == StFlush && (cnt_q == 2'd0 || out_free)) st_d = StDone;
        if (sha_en && hash_start) st_d = StActive;
        if (!sha_en) st_d = StIdle;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q           <= StIdle;
            cnt_q          <= 2'd0;
            acc_q          <= 24'h0;
            fifo_wvalid    <= 1'b0;
            fifo_wdata     <= '0;
            message_length <= 64'h0;
            err_strb       <= 1'b0;
            err_drop       <= 1'b0;
        end else begin
            st_q     <= st_d;
            err_strb <= accept && st_q == StActive && !legal;
            err_drop <= accept && (st_q == StIdle || st_q == StDone);
            if (fifo_wvalid && fifo_wready) fifo_wvalid <= 1'b0;
            if (take) begin
                message_length <= message_length + {58'h0, n, 3'b000};
                cnt_q          <= total[1:0];
                acc_q          <= total[2] ? merged[23:0] : merged[55:32];
                if (total[2]) begin
                    fifo_wdata  <= {merged[55:24], 4'hf};
                    fifo_wvalid <= 1'b1;
                end
            end
            if (flush_load) begin
                fifo_wdata  <= {acc_m, 8'h00, fmask};
                fifo_wvalid <= 1'b1;
                cnt_q       <= 2'd0;
            end
            if (wipe_secret) begin
                acc_q           <= wipe_v[23:0];
                fifo_wdata.data <= wipe_v;
            end
            // Restart discards everything in flight; the FIFO is cleared by the same pulse.
            if (hash_start) begin
                cnt_q          <= 2'd0;
                acc_q          <= 24'h0;
                message_length <= 64'h0;
                fifo_wvalid    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sha2_msg_pack.sv
// tb_sha2_msg_pack: directed vectors with hand-computed expectations for sha2_msg_pack.
module tb_sha2_msg_pack;
    import hmac_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        sha_en = 1'b0, hash_start = 1'b0, hash_process = 1'b0, wipe_secret = 1'b0;
    sha_word_t   wipe_v = '0;
    logic        msg_wvalid = 1'b0;
    logic [31:0] msg_wdata = '0;
    logic [3:0]  msg_wstrb = '0;
    logic        msg_wready, fifo_wvalid, fifo_wready = 1'b1, err_strb, err_drop;
    sha_fifo_t   fifo_wdata;
    logic [63:0] message_length;
    int          nvec = 0, nfail = 0;

    sha2_msg_pack dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .sha_en(sha_en), .hash_start(hash_start),
        .hash_process(hash_process), .wipe_secret(wipe_secret), .wipe_v(wipe_v),
        .msg_wvalid(msg_wvalid), .msg_wdata(msg_wdata), .msg_wstrb(msg_wstrb),
        .msg_wready(msg_wready), .fifo_wvalid(fifo_wvalid), .fifo_wdata(fifo_wdata),
        .fifo_wready(fifo_wready), .message_length(message_length),
        .err_strb(err_strb), .err_drop(err_drop)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] d, input logic [3:0] s);
        msg_wvalid = 1'b1;
        msg_wdata  = d;
        msg_wstrb  = s;
        tick();
        msg_wvalid = 1'b0;
    endtask

    task automatic start();
        hash_start = 1'b1;
        tick();
        hash_start = 1'b0;
    endtask

    initial begin
        tick();
        tick();
        rst_ni = 1'b1;
        #1;
        chk("rst_wready", 64'(msg_wready), 64'd1);
        chk("rst_fvalid", 64'(fifo_wvalid), 64'd0);
        chk("rst_len", message_length, 64'd0);
        chk("rst_fdata", {28'h0, fifo_wdata}, 64'h0);
        chk("rst_err", {62'h0, err_strb, err_drop}, 64'd0);

        sha_en = 1'b1;
        tick();
        wr(32'h11223344, 4'b1111);
        chk("idle_err_drop", 64'(err_drop), 64'd1);
        chk("idle_no_entry", 64'(fifo_wvalid), 64'd0);
        tick();
        chk("err_drop_pulse", 64'(err_drop), 64'd0);

        start();
        wr(32'h64636261, 4'b1111);
        chk("aligned_valid", 64'(fifo_wvalid), 64'd1);
        chk("aligned_data", {28'h0, fifo_wdata}, {28'h0, 32'h61626364, 4'hf});
        chk("aligned_len", message_length, 64'd32);
        tick();
        chk("aligned_drain", 64'(fifo_wvalid), 64'd0);

        start();
        chk("restart_len", message_length, 64'd0);
        wr(32'h000000AA, 4'b0001);
        chk("unal_partial_none", 64'(fifo_wvalid), 64'd0);
        wr(32'h00DDCCBB, 4'b0111);
        chk("unal_w0", {28'h0, fifo_wdata}, {28'h0, 32'hAABBCCDD, 4'hf});
        chk("unal_w0_valid", 64'(fifo_wvalid), 64'd1);
        wr(32'hFFEEDD11, 4'b1111);
        chk("unal_w1", {28'h0, fifo_wdata}, {28'h0, 32'h11DDEEFF, 4'hf});
        chk("unal_w1_valid", 64'(fifo_wvalid), 64'd1);
        chk("unal_len", message_length, 64'd64);
        hash_process = 1'b1;
        tick();
        hash_process = 1'b0;
        chk("unal_flush_none", 64'(fifo_wvalid), 64'd0);
        tick();
        chk("unal_done_none", 64'(fifo_wvalid), 64'd0);
        chk("unal_done_wready", 64'(msg_wready), 64'd1);
        chk("unal_len_hold", message_length, 64'd64);

        start();
        wr(32'h00CCBBAA, 4'b0111);
        chk("pf_no_word", 64'(fifo_wvalid), 64'd0);
        chk("pf_len", message_length, 64'd24);
        hash_process = 1'b1;
        tick();
        hash_process = 1'b0;
        chk("pf_flush_wready", 64'(msg_wready), 64'd0);
        chk("pf_n1_valid", 64'(fifo_wvalid), 64'd0);
        tick();
        chk("pf_n2_valid", 64'(fifo_wvalid), 64'd1);
        chk("pf_n2_data", {28'h0, fifo_wdata}, {28'h0, 32'hAABBCC00, 4'b1110});
        chk("pf_done_wready", 64'(msg_wready), 64'd1);
        wr(32'h12345678, 4'b1111);
        chk("done_err_drop", 64'(err_drop), 64'd1);
        chk("done_len_hold", message_length, 64'd24);

        start();
        fifo_wready = 1'b0;
        wr(32'h44332211, 4'b1111);
        chk("bp_valid", 64'(fifo_wvalid), 64'd1);
        chk("bp_wready_low", 64'(msg_wready), 64'd0);
        msg_wvalid = 1'b1;
        msg_wdata  = 32'h88776655;
        msg_wstrb  = 4'b1111;
        tick();
        chk("bp_hold_data", {28'h0, fifo_wdata}, {28'h0, 32'h11223344, 4'hf});
        chk("bp_hold_valid", 64'(fifo_wvalid), 64'd1);
        chk("bp_len_hold", message_length, 64'd32);
        fifo_wready = 1'b1;
        #1;
        chk("bp_release_wready", 64'(msg_wready), 64'd1);
        tick();
        msg_wvalid = 1'b0;
        chk("bp_next_data", {28'h0, fifo_wdata}, {28'h0, 32'h55667788, 4'hf});
        chk("bp_next_valid", 64'(fifo_wvalid), 64'd1);
        chk("bp_len", message_length, 64'd64);

        wr(32'hCAFEF00D, 4'b0110);
        chk("strb_err", 64'(err_strb), 64'd1);
        chk("strb_len", message_length, 64'd64);
        tick();
        chk("strb_pulse", 64'(err_strb), 64'd0);

        wr(32'h0000BBAA, 4'b0011);
        chk("mid_len", message_length, 64'd80);
        start();
        chk("mid_len_clr", message_length, 64'd0);
        chk("mid_valid_clr", 64'(fifo_wvalid), 64'd0);
        wr(32'h04030201, 4'b1111);
        chk("mid_cnt_clr", {28'h0, fifo_wdata}, {28'h0, 32'h01020304, 4'hf});

        fifo_wready = 1'b0;
        tick();
        chk("wipe_pre_valid", 64'(fifo_wvalid), 64'd1);
        wipe_secret = 1'b1;
        wipe_v      = 32'hDEADBEEF;
        tick();
        wipe_secret = 1'b0;
        chk("wipe_data", {28'h0, fifo_wdata}, {28'h0, 32'hDEADBEEF, 4'hf});
        chk("wipe_valid", 64'(fifo_wvalid), 64'd1);
        fifo_wready = 1'b1;
        tick();

        sha_en = 1'b0;
        tick();
        wr(32'h00000001, 4'b0001);
        chk("dis_err_drop", 64'(err_drop), 64'd1);
        chk("dis_len", message_length, 64'd32);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
